oq_ctr_update: RTL and testbench
================================

# oq_ctr_update

Read-modify-write engine for the per-output-queue counter file (packets/words in queue). It accepts increment/decrement events from the output-queue enqueue/dequeue logic and applies them to the dual-port register RAM over that RAM's port A. The RAM has one cycle of read latency and read-first behaviour. The block also supports a bulk clear of all queue entries. Port B of the RAM stays with the register-bus reader and is not touched here.

## Interface
Parameters:
- REG_WIDTH, 32, counter/RAM data width
- NUM_OUTPUT_QUEUES, 8, number of counter entries
- DELTA_WIDTH, 12, width of each inc/dec amount
- REG_FILE_ADDR_WIDTH, log2(NUM_OUTPUT_QUEUES), RAM address width (ceiling log2)

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- evt_valid  in  1  update event present
- evt_ready  out  1  event accepted when evt_valid & evt_ready at rising edge
- evt_q  in  REG_FILE_ADDR_WIDTH  target queue
- evt_inc  in  DELTA_WIDTH  amount added
- evt_dec  in  DELTA_WIDTH  amount subtracted
- clear_req  in  1  level request to zero all entries
- clear_busy  out  1  high while clear sweep runs
- ram_addr  out  REG_FILE_ADDR_WIDTH  RAM port A address
- ram_we  out  1  RAM port A write enable
- ram_din  out  REG_WIDTH  RAM port A write data
- ram_dout  in  REG_WIDTH  RAM port A registered read data
- upd_valid  out  1  one-cycle pulse: counter written
- upd_q  out  REG_FILE_ADDR_WIDTH  queue of last write
- upd_value  out  REG_WIDTH  value written
- sat_err  out  1  one-cycle pulse: result out of range

## Operation
- FSM states are IDLE, UPDATE and CLEAR. Reset state is IDLE.
- IDLE:
  - evt_ready = !clear_req.
  - ram_addr = evt_q (combinational), ram_we = 0.
  - If clear_req is high, go to CLEAR with clear index 0. Clear has priority over events.
  - Otherwise, if evt_valid is high, capture q/inc/dec and go to UPDATE.
- UPDATE:
  - ram_dout holds the old value.
  - Compute res = old + inc − dec in REG_WIDTH+2-bit signed arithmetic, with inc/dec zero-extended.
  - Drive ram_addr = captured q, ram_we = 1, ram_din = result.
  - Return to IDLE. evt_ready is 0 in this state.
- CLEAR:
  - Drive ram_addr = index, ram_we = 1, ram_din = 0. clear_busy = 1.
  - Index increments each cycle. After writing index NUM_OUTPUT_QUEUES−1, return to IDLE. Non-power-of-two counts never address beyond N−1.
  - clear_req must be deasserted by the requester, or a new sweep starts immediately.
  - clear_req asserted during UPDATE waits until IDLE. It is not dropped.
- In any state other than IDLE and CLEAR, ram_addr carries the captured queue.
- There is never more than one event in flight, so back-to-back events to the same queue need no forwarding. The second read is issued only after the first write.
- upd_valid, upd_q and upd_value are registered one cycle after each UPDATE write. They do not pulse during CLEAR.
- Reset mid-operation: outputs return to reset values immediately and any in-flight event is lost. RAM contents are not altered by reset.
- Output reset values:
  - evt_ready = 1 (subject to clear_req).
  - clear_busy, ram_we, upd_valid and sat_err = 0.
  - ram_addr = evt_q.
  - ram_din, upd_q and upd_value = 0.

## Timing
- Event accepted at edge N:
  - RAM reads during cycle N.
  - ram_we = 1 in cycle N+1.
  - upd_valid and sat_err pulse in cycle N+2.
- Event throughput is one per 2 cycles. evt_ready is next high in cycle N+2.
- A clear accepted at edge N writes entries 0..N−1 in cycles N+1..N+NUM_OUTPUT_QUEUES. clear_busy is high for exactly those cycles.

## Configuration
- OQ_CTR_SATURATE_EN defined:
  - If res < 0, write 0.
  - If res > 2^REG_WIDTH−1, write 2^REG_WIDTH−1.
  - sat_err pulses alongside upd_valid in either case.
- OQ_CTR_SATURATE_EN undefined:
  - Write res modulo 2^REG_WIDTH (wrap).
  - sat_err still pulses on out-of-range results but the value wraps.

## Test plan
- Reset, then clear_req for 1 cycle → clear_busy high for 8 cycles with ram_addr 0..7, ram_din = 0; read-back of all entries is 0.
- Event q=3, inc=5, dec=0 after clear → ram_we in the next cycle with din = 5; upd_valid with upd_q = 3, upd_value = 5 one cycle later.
- Back-to-back events on q=3 (+10, then −4, held valid) → second accepted 2 cycles after the first; final value 11; evt_ready pattern 1,0,1,0.
- q=2 holding 1, event dec=3 → with OQ_CTR_SATURATE_EN: value 0 and sat_err = 1; without: value 0xFFFFFFFE and sat_err = 1.
- q=7 holding 0xFFFFFFFF, inc=1 → saturate build writes 0xFFFFFFFF; wrap build writes 0; sat_err pulses in both.
- Assert reset_n low during UPDATE → ram_we drops asynchronously; state IDLE; subsequent event on the same queue reads the unmodified prior value.

Source files
------------

// File: rtl/oq_ctr_update.sv
// oq_ctr_update
//   Read-modify-write engine for the per-output-queue counter file. Applies
//   increment/decrement events to the counter RAM through its port A (one
//   cycle registered read latency, read-first) and can sweep-clear every entry.
//
//   Optional build macro: OQ_CTR_SATURATE_EN
//     defined   -> out-of-range results clamp to 0 / all-ones
//     undefined -> out-of-range results wrap modulo 2^REG_WIDTH
//   sat_err pulses on any out-of-range result in both builds.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   evt_valid/evt_ready   event handshake
//   evt_q/inc/dec         target queue and amounts (zero-extended)
//   clear_req/clear_busy  level request to zero all entries / sweep running
//   ram_addr/we/din/dout  RAM port A
//   upd_valid/q/value     registered report of each counter write
//   sat_err               registered pulse for an out-of-range result
module oq_ctr_update #(
   parameter int REG_WIDTH           = 32,
   parameter int NUM_OUTPUT_QUEUES   = 8,
   parameter int DELTA_WIDTH         = 12,
   parameter int REG_FILE_ADDR_WIDTH = $clog2(NUM_OUTPUT_QUEUES)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           evt_valid,
   output logic                           evt_ready,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] evt_q,
   input  logic [DELTA_WIDTH-1:0]         evt_inc,
   input  logic [DELTA_WIDTH-1:0]         evt_dec,
   input  logic                           clear_req,
   output logic                           clear_busy,
   output logic [REG_FILE_ADDR_WIDTH-1:0] ram_addr,
   output logic                           ram_we,
   output logic [REG_WIDTH-1:0]           ram_din,
   input  logic [REG_WIDTH-1:0]           ram_dout,
   output logic                           upd_valid,
   output logic [REG_FILE_ADDR_WIDTH-1:0] upd_q,
   output logic [REG_WIDTH-1:0]           upd_value,
   output logic                           sat_err
);

   localparam int RW = REG_WIDTH + 2;
   localparam logic [REG_FILE_ADDR_WIDTH-1:0] LAST_IDX =
      REG_FILE_ADDR_WIDTH'(NUM_OUTPUT_QUEUES - 1);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_CLEAR} state_t;

   state_t                         state_q, state_d;
   logic [REG_FILE_ADDR_WIDTH-1:0] evq_q, evq_d;
   logic [DELTA_WIDTH-1:0]         inc_q, inc_d;
   logic [DELTA_WIDTH-1:0]         dec_q, dec_d;
   logic [REG_FILE_ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                           upd_valid_q, upd_valid_d;
   logic [REG_FILE_ADDR_WIDTH-1:0] upd_q_q, upd_q_d;
   logic [REG_WIDTH-1:0]           upd_value_q, upd_value_d;
   logic                           sat_err_q, sat_err_d;

   logic signed [RW-1:0] res;
   logic                 res_neg, res_over, res_oor;
   logic [REG_WIDTH-1:0] wr_val;

   // Two guard bits: MSB is the sign, next bit flags overflow past all-ones.
   always_comb begin
      res      = $signed({2'b00, ram_dout}) + $signed(RW'(inc_q)) - $signed(RW'(dec_q));
      res_neg  = res[RW-1];
      res_over = !res[RW-1] && res[REG_WIDTH];
      res_oor  = res_neg || res_over;
`ifdef OQ_CTR_SATURATE_EN
      if (res_neg)       wr_val = '0;
      else if (res_over) wr_val = '1;
      else               wr_val = res[REG_WIDTH-1:0];
`else
      wr_val = res[REG_WIDTH-1:0];
`endif
   end

   always_comb begin
      state_d    = state_q;
      evq_d      = evq_q;
      inc_d      = inc_q;
      dec_d      = dec_q;
      idx_d      = idx_q;
      evt_ready  = 1'b0;
      clear_busy = 1'b0;
      ram_addr   = evq_q;
      ram_we     = 1'b0;
      ram_din    = '0;
      case (state_q)
         S_IDLE: begin
            evt_ready = !clear_req;
            ram_addr  = evt_q;
            if (clear_req) begin
               state_d = S_CLEAR;
               idx_d   = '0;
            end else if (evt_valid) begin
               state_d = S_UPDATE;
               evq_d   = evt_q;
               inc_d   = evt_inc;
               dec_d   = evt_dec;
            end
         end
         S_UPDATE: begin
            ram_we  = 1'b1;
            ram_din = wr_val;
            state_d = S_IDLE;
         end
         S_CLEAR: begin
            ram_addr   = idx_q;
            ram_we     = 1'b1;
            clear_busy = 1'b1;
            if (idx_q == LAST_IDX) state_d = S_IDLE;
            else                   idx_d   = idx_q + REG_FILE_ADDR_WIDTH'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      upd_valid_d = (state_q == S_UPDATE);
      sat_err_d   = (state_q == S_UPDATE) && res_oor;
      upd_q_d     = (state_q == S_UPDATE) ? evq_q  : upd_q_q;
      upd_value_d = (state_q == S_UPDATE) ? wr_val : upd_value_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         evq_q       <= '0;
         inc_q       <= '0;
         dec_q       <= '0;
         idx_q       <= '0;
         upd_valid_q <= 1'b0;
         upd_q_q     <= '0;
         upd_value_q <= '0;
         sat_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         evq_q       <= evq_d;
         inc_q       <= inc_d;
         dec_q       <= dec_d;
         idx_q       <= idx_d;
         upd_valid_q <= upd_valid_d;
         upd_q_q     <= upd_q_d;
         upd_value_q <= upd_value_d;
         sat_err_q   <= sat_err_d;
      end
   end

   assign upd_valid = upd_valid_q;
   assign upd_q     = upd_q_q;
   assign upd_value = upd_value_q;
   assign sat_err   = sat_err_q;

endmodule

// File: tb/tb_oq_ctr_update.sv
module tb_oq_ctr_update;

   localparam int  W    = 32;
   localparam int  N    = 8;
   localparam int  DW   = 12;
   localparam int  AW   = 3;
   localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          evt_valid, evt_ready;
   logic [AW-1:0] evt_q;
   logic [DW-1:0] evt_inc, evt_dec;
   logic          clear_req, clear_busy;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [W-1:0]  ram_din;
   logic [W-1:0]  ram_dout = '0;
   logic          upd_valid;
   logic [AW-1:0] upd_q;
   logic [W-1:0]  upd_value;
   logic          sat_err;

   always #5 clk = ~clk;

   oq_ctr_update #(
      .REG_WIDTH(W), .NUM_OUTPUT_QUEUES(N), .DELTA_WIDTH(DW), .REG_FILE_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_q(evt_q), .evt_inc(evt_inc), .evt_dec(evt_dec),
      .clear_req(clear_req), .clear_busy(clear_busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
      .upd_valid(upd_valid), .upd_q(upd_q), .upd_value(upd_value), .sat_err(sat_err)
   );

   // Counter RAM port A (registered read, read-first) plus a bench back door.
   logic [W-1:0]  mem [N];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [W-1:0]  poke_val = '0;
   always @(posedge clk) begin
      ram_dout <= mem[ram_addr];
      if (poke_en)     mem[poke_addr] <= poke_val;
      else if (ram_we) mem[ram_addr]  <= ram_din;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit done    = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural model: expected counter contents plus "what the engine is doing".
   longint model [N] = '{default: 0};
   bit     m_clear = 0, m_pend = 0, m_uv = 0, m_usat = 0, m_wsat = 0;
   int     m_idx = 0, m_wq = 0, m_uq = 0;
   longint m_wval = 0, m_uval = 0;

   always @(posedge clk or negedge reset_n) begin : mdl
      longint r, w;
      if (!reset_n) begin
         m_clear <= 0; m_pend <= 0; m_uv <= 0; m_usat <= 0; m_uq <= 0; m_uval <= 0;
      end else begin
         if (poke_en) model[poke_addr] <= longint'(poke_val);
         m_uv   <= m_pend;
         m_usat <= m_pend && m_wsat;
         if (m_pend) begin m_uq <= m_wq; m_uval <= m_wval; end
         if (m_clear) begin
            model[m_idx] <= 0;
            m_idx <= m_idx + 1;
            if (m_idx == N - 1) m_clear <= 0;
         end else if (m_pend) begin
            model[m_wq] <= m_wval;
            m_pend <= 0;
         end else if (clear_req) begin
            m_clear <= 1; m_idx <= 0;
         end else if (evt_valid) begin
            r = model[evt_q] + longint'(evt_inc) - longint'(evt_dec);
`ifdef OQ_CTR_SATURATE_EN
            w = (r < 0) ? 0 : ((r > MAXV) ? MAXV : r);
`else
            w = r & MAXV;
`endif
            m_pend <= 1; m_wq <= int'(evt_q); m_wval <= w; m_wsat <= (r < 0) || (r > MAXV);
         end
      end
   end

   // Per-cycle comparison against the model, plus capture of reports for literal checks.
   int busy_cnt = 0, upd_cyc = 0;
   logic [63:0] last_uq = 0, last_uval = 0, last_sat = 0;
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (done) break;
         chk("evt_ready", evt_ready, m_clear || m_pend ? 0 : !clear_req);
         chk("ram_we", ram_we, m_clear || m_pend);
         chk("clear_busy", clear_busy, m_clear);
         chk("ram_addr", ram_addr, m_clear ? m_idx : (m_pend ? m_wq : int'(evt_q)));
         chk("ram_din", ram_din, (!m_clear && m_pend) ? m_wval : 0);
         chk("upd_valid", upd_valid, m_uv);
         chk("sat_err", sat_err, m_usat);
         chk("upd_q", upd_q, m_uq);
         chk("upd_value", upd_value, m_uval);
         if (clear_busy) busy_cnt++;
         if (upd_valid) begin
            last_uq = upd_q; last_uval = upd_value; last_sat = sat_err; upd_cyc = cyc;
         end
      end
   end

   // Present an event at a negedge, hold it until accepted; optionally pull
   // reset half a cycle after acceptance (i.e. in the write cycle).
   task automatic send(input int q, input int inc, input int dec, input bit rst_mid,
                       output int acc_cyc);
      bit acc = 0;
      acc_cyc = -1;
      evt_q = AW'(q); evt_inc = DW'(inc); evt_dec = DW'(dec); evt_valid = 1'b1;
      for (int i = 0; i < 40 && !acc; i++) begin
         #1;
         acc = evt_ready;
         if (acc) acc_cyc = cyc;
         @(posedge clk);
         if (acc && rst_mid) begin
            #2 reset_n = 1'b0;
            #1 chk("reset_drops_we", ram_we, 0);
         end
         @(negedge clk);
      end
      evt_valid = 1'b0;
      if (!acc) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: got no evt_ready expected acceptance within 40 cycles");
      end
      if (rst_mid) begin
         @(posedge clk);
         @(negedge clk);
         reset_n = 1'b1;
      end
   endtask

   int a1, a2, a3;

   initial begin
      reset_n = 1'b0; evt_valid = 0; evt_q = '0; evt_inc = '0; evt_dec = '0; clear_req = 0;
      repeat (3) @(negedge clk);
      #1 chk("reset_ready", evt_ready, 1);
      chk("reset_upd_value", upd_value, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Bulk clear, one-cycle request
      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
      repeat (10) @(negedge clk);
      chk("clear_busy_cycles", busy_cnt, 8);
      for (int i = 0; i < N; i++) chk("cleared_entry", mem[i], 0);

      // Single increment and its latency
      send(3, 5, 0, 0, a1);
      repeat (3) @(negedge clk);
      chk("inc_upd_q", last_uq, 3);
      chk("inc_upd_value", last_uval, 5);
      chk("inc_latency", upd_cyc - a1, 2);
      chk("inc_ram", mem[3], 5);

      // Back-to-back events, held valid
      send(3, 10, 0, 0, a1);
      send(3, 0, 4, 0, a2);
      repeat (3) @(negedge clk);
      chk("b2b_spacing", a2 - a1, 2);
      chk("b2b_value", last_uval, 11);
      chk("b2b_ram", mem[3], 11);

      // Underflow
      send(2, 1, 0, 0, a1);
      send(2, 0, 3, 0, a1);
      repeat (3) @(negedge clk);
`ifdef OQ_CTR_SATURATE_EN
      chk("underflow_value", last_uval, 0);
`else
      chk("underflow_value", last_uval, 64'hFFFF_FFFE);
`endif
      chk("underflow_sat", last_sat, 1);

      // Overflow from all-ones
      poke_en = 1'b1; poke_addr = 3'd7; poke_val = 32'hFFFF_FFFF;
      @(negedge clk); poke_en = 1'b0;
      send(7, 1, 0, 0, a1);
      repeat (3) @(negedge clk);
`ifdef OQ_CTR_SATURATE_EN
      chk("overflow_ram", mem[7], 32'hFFFF_FFFF);
`else
      chk("overflow_ram", mem[7], 0);
`endif
      chk("overflow_sat", last_sat, 1);

      // Reset during the write cycle: prior value must survive
      send(5, 20, 0, 0, a1);
      repeat (3) @(negedge clk);
      send(5, 7, 0, 1, a2);
      chk("reset_kept_ram", mem[5], 20);
      send(5, 3, 0, 0, a3);
      repeat (3) @(negedge clk);
      chk("after_reset_value", last_uval, 23);
      chk("after_reset_ram", mem[5], 23);

      // Clear requested while an update is in flight waits for IDLE
      send(1, 9, 0, 0, a1);
      clear_req = 1'b1;
      repeat (2) @(negedge clk);
      clear_req = 1'b0;
      repeat (11) @(negedge clk);
      chk("clear2_busy_cycles", busy_cnt, 16);
      for (int i = 0; i < N; i++) chk("final_model_vs_ram", longint'(mem[i]), model[i]);
      chk("final_entry1", mem[1], 0);

      done = 1'b1;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected completion");
      $fatal(1, "timeout");
   end

endmodule
